dc_strobe_tx: RTL and testbench

- Transmit side of the data/strobe (d, c) latch-load interface: accepts a parallel word over a valid/ready handshake and serialises it onto a single d line with a gating strobe c.
- Timing is built so that a level-sensitive gated latch on the far end captures each bit cleanly: d is set up before c rises, held while c is high, and held after c falls.
- Sits between a word producer and a chain or bank of d/c latches in the lab datapath.

---
 rtl/dc_strobe_tx_if.sv | 23 ++
 rtl/dc_strobe_tx.sv | 130 +++++++++++++
 tb/tb_dc_strobe_tx.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/dc_strobe_tx_if.sv
// Handshake and latch-side signals of the data/strobe transmitter.
// The producer drives the master side; the transmitter is the slave.
interface dc_strobe_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             ready_out;
    logic             d;
    logic             c;
    logic             busy;
    logic             done;

    modport master (
        output data_in, valid_in,
        input  ready_out, d, c, busy, done
    );

    modport slave (
        input  data_in, valid_in,
        output ready_out, d, c, busy, done
    );
endinterface

// File: rtl/dc_strobe_tx.sv
// Serialises a parallel word onto d with a gating strobe c, timed so that a
// level-sensitive latch sees d set up before, stable during and held after c.
module dc_strobe_tx #(
    parameter int WIDTH     = 8,
    parameter int SETUP     = 1,
    parameter int PULSE     = 2,
    parameter int HOLD      = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic         clk,
    input logic         rst,
    dc_strobe_tx_if.slave bus
);

    localparam int MAX_PHASE = (SETUP > PULSE) ? ((SETUP > HOLD) ? SETUP : HOLD)
                                               : ((PULSE > HOLD) ? PULSE : HOLD);
    localparam int PW = $clog2(MAX_PHASE + 1);
    localparam int BW = $clog2(WIDTH + 1);

    localparam logic [PW-1:0] SETUP_LAST = PW'(SETUP - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE - 1);
    localparam logic [PW-1:0] HOLD_LAST  = PW'(HOLD - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [PW-1:0]    phase_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [WIDTH-1:0] load_word;
    logic             accept;
    logic             d_next;
    logic             c_next;
    logic             busy_next;
    logic             done_next;
    logic             ready_next;
    logic             d_r;
    logic             c_r;
    logic             busy_r;
    logic             done_r;
    logic             ready_r;

    assign accept        = bus.valid_in && ready_r;
    assign bus.d         = d_r;
    assign bus.c         = c_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.ready_out = ready_r;

    // LSB-first words are reversed on load so the shifter always moves toward the MSB end.
    always_comb begin
        load_word = bus.data_in;
        if (!MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                load_word[i] = bus.data_in[WIDTH-1-i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            phase_cnt <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            d_r       <= 1'b0;
            c_r       <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ready_r   <= 1'b1;
        end else begin
            state <= state_next;
            shreg <= shreg_next;
            if (state_next != state || state == ST_IDLE) begin
                phase_cnt <= '0;
            end else begin
                phase_cnt <= phase_cnt + PW'(1);
            end
            if (state == ST_IDLE && accept) begin
                bit_cnt <= '0;
            end else if (state == ST_HOLD && state_next == ST_SETUP) begin
                bit_cnt <= bit_cnt + BW'(1);
            end
            d_r     <= d_next;
            c_r     <= c_next;
            busy_r  <= busy_next;
            done_r  <= done_next;
            ready_r <= ready_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (accept) state_next = ST_SETUP;
            ST_SETUP:  if (phase_cnt == SETUP_LAST) state_next = ST_STROBE;
            ST_STROBE: if (phase_cnt == PULSE_LAST) state_next = ST_HOLD;
            ST_HOLD: begin
                if (phase_cnt == HOLD_LAST) begin
                    state_next = (bit_cnt == BIT_LAST) ? ST_IDLE : ST_SETUP;
                end
            end
            default:   state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so d only moves on HOLD->SETUP.
    always_comb begin
        shreg_next = shreg;
        if (state == ST_IDLE && accept) begin
            shreg_next = load_word;
        end else if (state == ST_HOLD && state_next == ST_SETUP) begin
            shreg_next = shreg << 1;
        end
        d_next     = (state_next != ST_IDLE) && shreg_next[WIDTH-1];
        c_next     = (state_next == ST_STROBE);
        busy_next  = (state_next != ST_IDLE);
        ready_next = (state_next == ST_IDLE);
        done_next  = (state == ST_HOLD) && (state_next == ST_IDLE);
    end

endmodule

// File: tb/tb_dc_strobe_tx.sv
// Scoreboard bench for dc_strobe_tx: a 4-bit MSB-first, a 4-bit LSB-first and
// an 8-bit MSB-first instance, each checked cycle by cycle against expected queues.
module tb_dc_strobe_tx;

    localparam int SETUP = 1;
    localparam int PULSE = 2;
    localparam int HOLD  = 1;
    localparam logic [4:0] IDLE_EXP = 5'b00001;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dc_strobe_tx_if #(.WIDTH(4)) bus0 ();
    dc_strobe_tx_if #(.WIDTH(4)) bus1 ();
    dc_strobe_tx_if #(.WIDTH(8)) bus2 ();

    dc_strobe_tx #(.WIDTH(4), .SETUP(SETUP), .PULSE(PULSE), .HOLD(HOLD), .MSB_FIRST(1'b1))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    dc_strobe_tx #(.WIDTH(4), .SETUP(SETUP), .PULSE(PULSE), .HOLD(HOLD), .MSB_FIRST(1'b0))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    dc_strobe_tx #(.WIDTH(8), .SETUP(SETUP), .PULSE(PULSE), .HOLD(HOLD), .MSB_FIRST(1'b1))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int total = 0;
    int bad   = 0;

    // Each entry is {busy, c, d, done, ready_out} for one cycle.
    logic [4:0] q0[$];
    logic [4:0] q1[$];
    logic [4:0] q2[$];

    bit         checking = 1'b0;
    logic       rst_prev = 1'b1;
    logic [2:0] pc = '0;
    logic [2:0] pd = '0;

    task automatic push_exp(int idx, logic [4:0] v);
        case (idx)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic push_word(int idx, logic [7:0] data);
        int   width;
        logic b;
        width = (idx == 2) ? 8 : 4;
        for (int k = 0; k < width; k++) begin
            b = (idx != 1) ? data[width-1-k] : data[k];
            repeat (SETUP) push_exp(idx, {1'b1, 1'b0, b, 1'b0, 1'b0});
            repeat (PULSE) push_exp(idx, {1'b1, 1'b1, b, 1'b0, 1'b0});
            repeat (HOLD)  push_exp(idx, {1'b1, 1'b0, b, 1'b0, 1'b0});
        end
        push_exp(idx, 5'b00011);
    endtask

    task automatic set_input(int idx, logic valid, logic [7:0] data);
        case (idx)
            0: begin
                bus0.valid_in = valid;
                bus0.data_in  = data[3:0];
            end
            1: begin
                bus1.valid_in = valid;
                bus1.data_in  = data[3:0];
            end
            default: begin
                bus2.valid_in = valid;
                bus2.data_in  = data;
            end
        endcase
    endtask

    function automatic logic ready_of(int idx);
        case (idx)
            0:       return bus0.ready_out;
            1:       return bus1.ready_out;
            default: return bus2.ready_out;
        endcase
    endfunction

    task automatic check_output(int idx, logic [4:0] obs);
        logic [4:0] exp;
        exp = IDLE_EXP;
        case (idx)
            0:       if (q0.size() > 0) exp = q0.pop_front();
            1:       if (q1.size() > 0) exp = q1.pop_front();
            default: if (q2.size() > 0) exp = q2.pop_front();
        endcase
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL dut%0d_cycle busy/c/d/done/ready observed=%b expected=%b at %0t",
                   idx, obs, exp, $time);
        end
    endtask

    task automatic check_invariant(int idx, logic c_now, logic d_now, logic c_old, logic d_old);
        if (c_now || (c_now != c_old)) begin
            total++;
            assert (d_now === d_old) else begin
                bad++;
                $error("[TB] FAIL dut%0d_d_stable observed d=%b expected d=%b (c=%b prev c=%b) at %0t",
                       idx, d_now, d_old, c_now, c_old, $time);
            end
        end
    endtask

    // Outputs are sampled on the falling edge, away from the register updates.
    always @(negedge clk) begin
        if (checking) begin
            check_output(0, {bus0.busy, bus0.c, bus0.d, bus0.done, bus0.ready_out});
            check_output(1, {bus1.busy, bus1.c, bus1.d, bus1.done, bus1.ready_out});
            check_output(2, {bus2.busy, bus2.c, bus2.d, bus2.done, bus2.ready_out});
            if (!rst_prev) begin
                check_invariant(0, bus0.c, bus0.d, pc[0], pd[0]);
                check_invariant(1, bus1.c, bus1.d, pc[1], pd[1]);
                check_invariant(2, bus2.c, bus2.d, pc[2], pd[2]);
            end
        end
        pc       = {bus2.c, bus1.c, bus0.c};
        pd       = {bus2.d, bus1.d, bus0.d};
        rst_prev = rst;
    end

    task automatic apply_stimulus(int idx, logic [7:0] data, bit keep_valid);
        logic r;
        bit   got;
        got = 1'b0;
        set_input(idx, 1'b1, data);
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            r = ready_of(idx);
            @(posedge clk);
            #1;
            if (r) got = 1'b1;
        end
        total++;
        assert (got) else begin
            bad++;
            $error("[TB] FAIL dut%0d_accept observed=no accept expected=accept of %h", idx, data);
        end
        if (got) push_word(idx, data);
        if (!keep_valid) set_input(idx, 1'b0, data);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q0.size() + q1.size() + q2.size()) > 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        total++;
        assert (n < 400) else begin
            bad++;
            $error("[TB] FAIL drain_timeout observed=%0d cycles expected=<400", n);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        set_input(0, 1'b0, 8'h00);
        set_input(1, 1'b0, 8'h00);
        set_input(2, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checking = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] single word 1011, MSB first");
        apply_stimulus(0, 8'h0B, 1'b0);
        set_input(0, 1'b0, 8'h04);
        wait_drain();

        $display("[TB] single word 1000, LSB first");
        apply_stimulus(1, 8'h08, 1'b0);
        wait_drain();

        $display("[TB] back-to-back A5 then 3C");
        apply_stimulus(2, 8'hA5, 1'b1);
        apply_stimulus(2, 8'h3C, 1'b0);
        wait_drain();

        $display("[TB] valid with FF while busy is ignored");
        apply_stimulus(2, 8'h5A, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        set_input(2, 1'b1, 8'hFF);
        repeat (5) @(posedge clk);
        #1;
        set_input(2, 1'b0, 8'hFF);
        wait_drain();

        $display("[TB] reset in the middle of a strobe");
        apply_stimulus(0, 8'h0D, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1;
        q0.delete();
        q1.delete();
        q2.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        $display("[TB] recovery word after reset");
        apply_stimulus(0, 8'h06, 1'b0);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
